// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t   : arbiter FSM states
//   DATA_BITS_DEF : default byte width, matches uart_tx
//   cnt_w()       : width of a counter that must hold values 0..n-1
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK  = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_t;

  localparam int DATA_BITS_DEF = 8;

  // At least one bit, so tiny timeouts still give a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority encoder.
//   req : request vector
//   ptr : index with highest priority (must be < NUM_REQ)
//   any : at least one request set
//   idx : first set bit scanning from ptr upward, wrapping at NUM_REQ
// The wrap is done modulo NUM_REQ, not modulo 2**IW, so non-power-of-two
// requester counts never produce an out-of-range index.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [IW-1:0]      idx
);

  assign any = |req;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int c;
    logic [IW-1:0] ci;
    c   = 0;
    ci  = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IW'(c);
      if (req[ci]) idx = ci;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter sharing one uart_tx among NUM_REQ
// byte-stream requesters. A winner owns the transmitter until its last byte
// has left the buffer and the line is idle; a stall timeout releases a
// requester that stops supplying bytes mid-packet.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester byte valid
//   req_data     : requester i at [i*DATA_BITS +: DATA_BITS]
//   req_last     : final byte of packet (qualified by req_valid)
//   req_ready    : byte accepted when req_valid[i] && req_ready[i]
//   tx_valid/tx_data/tx_ready : handshake to uart_tx input
//   tx_busy      : uart_tx still shifting a byte out
//   grant_valid  : a requester owns the transmitter
//   grant_id     : current owner
//   timeout_err  : one-cycle pulse on forced release
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_valid,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_ready,
  input  logic                         tx_busy,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  arb_state_t state, state_nxt;

  logic [IW-1:0]                     owner, rr_ptr, owner_inc;
  logic                              buf_valid;
  logic [DATA_BITS-1:0]              buf_data;
  logic [CW-1:0]                     stall_cnt;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] data_arr;
  logic                              pick_any;
  logic [IW-1:0]                     pick_idx;
  logic                              accept, tx_fire, stall, expire, drain_done;

  assign data_arr = req_data;

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  // Ready only from registered state: no path from req_valid.
  always_comb begin
    req_ready = '0;
    if (state == S_LOCK && !buf_valid) req_ready[owner] = 1'b1;
  end

  assign accept     = req_valid[owner] && req_ready[owner];
  assign tx_fire    = buf_valid && tx_ready;
  assign stall      = (state == S_LOCK) && !buf_valid && !req_valid[owner];
  assign expire     = stall && (stall_cnt == CNT_MAX);
  // Line is truly idle: nothing buffered, nothing shifting.
  assign drain_done = !buf_valid && !tx_busy && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (pick_any) state_nxt = S_LOCK;
      S_LOCK:  if ((accept && req_last[owner]) || expire) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= '0;
      rr_ptr      <= '0;
      buf_valid   <= 1'b0;
      buf_data    <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (state == S_IDLE && pick_any) owner <= pick_idx;
      if (state == S_DRAIN && drain_done) rr_ptr <= owner_inc;
      // Accept and drain are exclusive: ready needs an empty buffer.
      if (accept) begin
        buf_valid <= 1'b1;
        buf_data  <= data_arr[owner];
      end else if (tx_fire) begin
        buf_valid <= 1'b0;
      end
      // Stall counter lives only inside one LOCK period; it saturates
      // rather than wrapping.
      if (state != S_LOCK || accept)               stall_cnt <= '0;
      else if (stall && stall_cnt != CNT_MAX)      stall_cnt <= stall_cnt + CW'(1);
    end
  end

  assign tx_valid    = buf_valid;
  assign tx_data     = buf_data;
  assign grant_valid = (state != S_IDLE);
  assign grant_id    = owner;

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin, packet-locked arbiter that shares one `uart_tx` transmitter among `NUM_REQ` byte-stream requesters. It sits between the requesters (hash-result reporter, debug console, status beacon, ...) and the single `uart_tx`. Once a requester wins, it owns the transmitter until its `last` byte has been handed over and the line has gone idle. A per-packet stall timeout stops a dead requester from holding the line.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_BITS`, default 8: byte width; must match `uart_tx`.
- `TIMEOUT_CYC`, default 1_000_000: clk cycles an owner may stall mid-packet before forced release.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: per-requester byte valid.
- `req_data`, in, `NUM_REQ*DATA_BITS`: requester i occupies bits `[i*DATA_BITS +: DATA_BITS]`.
- `req_last`, in, `NUM_REQ`: marks the final byte of a packet; qualified by `req_valid`.
- `req_ready`, out, `NUM_REQ`: byte accepted when `req_valid[i] && req_ready[i]`.
- `tx_valid`, out, 1: drives `uart_tx.in_valid`.
- `tx_data`, out, `DATA_BITS`: drives `uart_tx.in_data`.
- `tx_ready`, in, 1: from `uart_tx.in_ready`.
- `tx_busy`, in, 1: from `uart_tx.busy`.
- `grant_valid`, out, 1: high while a requester owns the transmitter (LOCK or DRAIN).
- `grant_id`, out, `$clog2(NUM_REQ)`: current owner.
- `timeout_err`, out, 1: one-cycle pulse on forced release.

## Operation
- States: IDLE, LOCK, DRAIN.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit scanning from `rr_ptr` upward with wrap.
  - Register the pick as owner and go to LOCK next cycle.
  - `req_ready` is all zero in IDLE.
- **LOCK**
  - `req_ready[owner] = !buf_valid`; all other `req_ready` bits are 0.
  - On accept: capture data into the 1-entry output buffer, set `buf_valid`, and capture the `last` flag.
  - `tx_valid = buf_valid` and `tx_data = buf_data`.
  - `buf_valid` clears on `tx_valid && tx_ready`.
  - Accepting a byte with `last=1` moves to DRAIN.
- **DRAIN**
  - Wait until `!buf_valid && !tx_busy && tx_ready`.
  - Then set `rr_ptr = (owner+1) mod NUM_REQ` and return to IDLE.
  - This guarantees that packets never interleave on the line.
- **Stall timeout**
  - Counter runs in LOCK while `!buf_valid && !req_valid[owner]`; it clears on any accept.
  - On reaching `TIMEOUT_CYC-1`: pulse `timeout_err` and go to DRAIN.
  - `rr_ptr` advances as in the normal case.
- **Width and wrap rules**
  - `rr_ptr` and `owner` wrap modulo `NUM_REQ`; this must hold for non-power-of-two `NUM_REQ`.
  - The timeout counter is `$clog2(TIMEOUT_CYC)` bits and saturates; it never wraps.
- **Simultaneous events**
  - Buffer drain and a new accept in the same cycle are impossible, because ready requires the buffer to be empty.
  - A request arriving in the same cycle the arbiter returns to IDLE is arbitrated on the following cycle.

## Timing
- **Reset values:**
  - `req_ready=0`, `tx_valid=0`, `tx_data=0`.
  - `grant_valid=0`, `grant_id=0`, `timeout_err=0`.
  - `rr_ptr=0`, state IDLE, buffer empty, counter 0.
- **Reset mid-operation:** reset wins over everything. The buffered byte is dropped and `tx_valid` falls on the cycle after `rst` is sampled high.
- **Latency:**
  - `req_valid` in IDLE → `grant_valid` high 1 cycle later.
  - `req_ready` is high in that same LOCK cycle, if the buffer is empty.
- **Buffer path:** accept at cycle t → `tx_valid` high at t+1.
- **Throughput:** at most one byte every 2 cycles, far above the baud rate.
- **Handshakes:**
  - `tx_valid` stays asserted, with `tx_data` stable, until `tx_ready`.
  - `req_ready` depends only on registered state (no combinational path from `req_valid`).
- **Priority after reset:** requester 0 has priority.

## Structure
- Shared package `uart_pkg`:
  - `arb_state_t` enum {S_IDLE, S_LOCK, S_DRAIN}.
  - Default `DATA_BITS`.
- Sub-module `uart_rr_pick`: combinational rotate-priority encoder.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `any` and `idx`.
  - Verified standalone.

## Test plan
- **Single packet:** requester 2 sends 3 bytes 0xA5,0x3C,0x7E with last on 0x7E, and `tx_ready` is held low 5 cycles per byte. → `tx_data` shows the 3 bytes in order; `grant_id=2` throughout; IDLE only after `tx_busy` falls.
- **Round-robin fairness:** all 4 requesters hold 1-byte packets continuously. → Grant order is 0,1,2,3,0,…; no requester is granted twice in a row.
- **No interleaving:** req1 sends 4 bytes while req0 is pending. → All of req1's bytes appear before any byte of req0; `req_ready[0]` stays 0 for the whole period.
- **Timeout:** `TIMEOUT_CYC=16`; req3 sends one non-last byte, then drops `req_valid`. → `timeout_err` pulses exactly once, 16 cycles after the buffer empties; req0 is granted next.
- **Reset mid-packet:** `rst` is asserted for 1 cycle while the buffer is full. → Next cycle: `tx_valid=0`, `grant_valid=0`; first grant after reset goes to the lowest pending index.
- **Non-power-of-two wrap:** `NUM_REQ=3`, all requesters active. → Grant sequence is 0,1,2,0 with no out-of-range `grant_id`.
